// File: rtl/top_pkg.sv
// Shared constants for the teaching CPU: opcodes, ALU ops, program ROM and hex font.
package top_pkg;

  localparam logic [5:0] OpRType = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpOri   = 6'h0D;

  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnSlt = 6'h2A;

  typedef enum logic [2:0] {AluAdd, AluSub, AluAnd, AluOr, AluSlt} alu_op_e;

  localparam int unsigned ProgWords = 11;

  localparam logic [31:0] ProgRom [ProgWords] = '{
    32'h201D_00FC,  // addi $29,$0,0x00FC
    32'h2001_0008,  // addi $1,$0,8
    32'h2002_0002,  // addi $2,$0,2
    32'h0022_1820,  // add  $3,$1,$2
    32'h0022_2022,  // sub  $4,$1,$2
    32'h0022_2824,  // and  $5,$1,$2
    32'h0022_3025,  // or   $6,$1,$2
    32'h0041_382A,  // slt  $7,$2,$1
    32'h1000_0001,  // beq  $0,$0,+1
    32'h2008_0001,  // addi $8,$0,1 (skipped)
    32'h0800_0000   // j    0
  };

  // Active-low {dp, g..a}; dp kept off.
  localparam logic [7:0] HexSeg [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  function automatic logic [31:0] alu_calc(alu_op_e op, logic [31:0] a, logic [31:0] b);
    logic [31:0] res;
    case (op)
      AluAdd:  res = a + b;
      AluSub:  res = a - b;
      AluAnd:  res = a & b;
      AluOr:   res = a | b;
      AluSlt:  res = {31'b0, $signed(a) < $signed(b)};
      default: res = a + b;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/seg_display.sv
// Scanned 4-digit and serial 8-digit 7-segment drivers for a 32-bit display value.
module seg_display import top_pkg::*; #(
  parameter int unsigned ScanW  = 17,
  parameter int unsigned SerDiv = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] value_i,
  output logic [3:0]  an_o,
  output logic [7:0]  seg_o,
  output logic        sclk_o,
  output logic        sclr_o,
  output logic        sdo_o,
  output logic        spen_o
);

  localparam int unsigned DivW = (SerDiv > 1) ? $clog2(SerDiv) : 1;

  typedef enum logic [1:0] {StLoad, StShift, StPen} ser_state_e;

  logic [ScanW-1:0] scan_q;
  logic [3:0]       an_q;
  logic [7:0]       seg_q;
  logic [1:0]       digit;
  logic [3:0]       nib;

  assign digit = scan_q[ScanW-1 -: 2];
  assign nib   = value_i[{1'b0, digit, 2'b00} +: 4];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      scan_q <= '0;
      an_q   <= 4'hF;
      seg_q  <= 8'hFF;
    end else begin
      scan_q <= scan_q + ScanW'(1);
      an_q   <= ~(4'b0001 << digit);
      seg_q  <= HexSeg[nib];
    end
  end

  assign an_o  = an_q;
  assign seg_o = seg_q;

  ser_state_e       state_q, state_d;
  logic [DivW-1:0]  div_q, div_d;
  logic [5:0]       bit_q, bit_d;
  logic [63:0]      frame_q, frame_d;
  logic             sclk_q, sclk_d;
  logic [63:0]      frame_load;

  // Digit 7 lands in the top byte so it leaves first.
  always_comb begin
    frame_load = '0;
    for (int d = 0; d < 8; d++) begin
      frame_load[8*d +: 8] = HexSeg[value_i[4*d +: 4]];
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    frame_d = frame_q;
    sclk_d  = sclk_q;
    unique case (state_q)
      StLoad: begin
        frame_d = frame_load;
        bit_d   = '0;
        div_d   = '0;
        sclk_d  = 1'b0;
        state_d = StShift;
      end
      StShift: begin
        if (div_q == DivW'(SerDiv - 1)) begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // Falling edge: data advances only while the clock is low.
            sclk_d = 1'b0;
            if (bit_q == 6'd63) begin
              state_d = StPen;
            end else begin
              bit_d   = bit_q + 6'd1;
              frame_d = {frame_q[62:0], 1'b0};
            end
          end
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      StPen:   state_d = StLoad;
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StLoad;
      div_q   <= '0;
      bit_q   <= '0;
      frame_q <= '0;
      sclk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      frame_q <= frame_d;
      sclk_q  <= sclk_d;
    end
  end

  assign sclk_o = sclk_q;
  assign sclr_o = 1'b1;
  assign sdo_o  = frame_q[63];
  assign spen_o = (state_q == StPen);

endmodule

// File: rtl/top.sv
// Board top: single-cycle MIPS-subset core stepped by SW[5], with 7-segment state display.
// Define STEP_BYPASS_EN to step on every clock instead of on SW[5] rising edges.
module top import top_pkg::*; #(
  parameter int unsigned SCAN_W     = 17,
  parameter int unsigned SER_DIV    = 2,
  parameter int unsigned IMEM_DEPTH = 64
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [15:0] SW,
  output logic [3:0]  AN,
  output logic [7:0]  SEGMENT,
  output logic        SEGLED_CLK,
  output logic        SEGLED_CLR,
  output logic        SEGLED_DO,
  output logic        SEGLED_PEN
);

  localparam logic [31:0] PcMask = 32'(IMEM_DEPTH * 4 - 1);

  logic        sw5_s1_q, sw5_s2_q, sw5_prev_q;
  logic        step;
  logic [31:0] pc_q;
  logic [31:0] rf_q [32];

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      sw5_s1_q   <= 1'b0;
      sw5_s2_q   <= 1'b0;
      sw5_prev_q <= 1'b0;
    end else begin
      sw5_s1_q   <= SW[5];
      sw5_s2_q   <= sw5_s1_q;
      sw5_prev_q <= sw5_s2_q;
    end
  end

`ifdef STEP_BYPASS_EN
  logic unused_sync;
  assign unused_sync = sw5_s2_q ^ sw5_prev_q;
  assign step = 1'b1;
`else
  assign step = sw5_s2_q & ~sw5_prev_q;
`endif

  logic [31:0] rom_idx, instr;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sext, imm_zext, rs_data, rt_data;

  assign rom_idx  = 32'(pc_q[7:2]);
  assign instr    = (rom_idx < ProgWords) ? ProgRom[rom_idx[3:0]] : '0;
  assign opcode   = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign funct    = instr[5:0];
  assign imm_sext = {{16{instr[15]}}, instr[15:0]};
  assign imm_zext = {16'b0, instr[15:0]};
  assign rs_data  = rf_q[rs];
  assign rt_data  = rf_q[rt];

  alu_op_e     alu_op;
  logic [31:0] alu_b, alu_res;
  logic        rf_we, is_beq, is_j;
  logic [4:0]  wr_idx;

  always_comb begin
    alu_op = AluAdd;
    alu_b  = rt_data;
    rf_we  = 1'b0;
    wr_idx = rd;
    is_beq = 1'b0;
    is_j   = 1'b0;
    case (opcode)
      OpRType: begin
        rf_we = 1'b1;
        case (funct)
          FnAdd:   alu_op = AluAdd;
          FnSub:   alu_op = AluSub;
          FnAnd:   alu_op = AluAnd;
          FnOr:    alu_op = AluOr;
          FnSlt:   alu_op = AluSlt;
          default: rf_we  = 1'b0;
        endcase
      end
      OpAddi: begin
        alu_b  = imm_sext;
        rf_we  = 1'b1;
        wr_idx = rt;
      end
      OpOri: begin
        alu_op = AluOr;
        alu_b  = imm_zext;
        rf_we  = 1'b1;
        wr_idx = rt;
      end
      OpBeq: begin
        alu_op = AluSub;
        is_beq = 1'b1;
      end
      OpJ:     is_j = 1'b1;
      default: ;
    endcase
  end

  assign alu_res = alu_calc(alu_op, rs_data, alu_b);

  logic [31:0] pc_plus4, next_pc_raw, next_pc;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    next_pc_raw = pc_plus4;
    if (is_j) begin
      next_pc_raw = {pc_plus4[31:28], instr[25:0], 2'b00};
    end else if (is_beq && (rs_data == rt_data)) begin
      next_pc_raw = pc_plus4 + {imm_sext[29:0], 2'b00};
    end
  end

  assign next_pc = next_pc_raw & PcMask;

  // $0 is never written, so it reads back as zero without a read-side mux.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      pc_q <= '0;
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= '0;
      end
    end else if (step) begin
      pc_q <= next_pc;
      if (rf_we && (wr_idx != 5'd0)) begin
        rf_q[wr_idx] <= alu_res;
      end
    end
  end

  logic [31:0] disp_v;

  always_comb begin
    disp_v = '0;
    case (SW[15:13])
      3'b000:  disp_v = pc_q;
      3'b001:  disp_v = next_pc;
      3'b010:  disp_v = {22'b0, rs, rt};
      3'b011:  disp_v = rs_data;
      3'b100:  disp_v = rt_data;
      3'b101:  disp_v = alu_res;
      3'b110:  disp_v = instr;
      default: disp_v = rf_q[SW[4:0]];
    endcase
  end

  logic unused_bits;
  assign unused_bits = ^{SW[12:6], instr[10:6]};

  seg_display #(
    .ScanW  (SCAN_W),
    .SerDiv (SER_DIV)
  ) u_disp (
    .clk_i   (CLK),
    .rst_ni  (Reset),
    .value_i (disp_v),
    .an_o    (AN),
    .seg_o   (SEGMENT),
    .sclk_o  (SEGLED_CLK),
    .sclr_o  (SEGLED_CLR),
    .sdo_o   (SEGLED_DO),
    .spen_o  (SEGLED_PEN)
  );

endmodule

// File: tb/tb_top.sv
// Scoreboard bench for top: stimulus queues expected observations, monitors compare them.
module tb_top;

  localparam int unsigned ScanW = 6;  // 16 cycles per digit keeps scan checks short

  logic        CLK = 1'b0;
  logic        Reset;
  logic [15:0] SW;
  logic [3:0]  AN;
  logic [7:0]  SEGMENT;
  logic        SEGLED_CLK, SEGLED_CLR, SEGLED_DO, SEGLED_PEN;

  top #(
    .SCAN_W     (ScanW),
    .SER_DIV    (2),
    .IMEM_DEPTH (64)
  ) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .SW         (SW),
    .AN         (AN),
    .SEGMENT    (SEGMENT),
    .SEGLED_CLK (SEGLED_CLK),
    .SEGLED_CLR (SEGLED_CLR),
    .SEGLED_DO  (SEGLED_DO),
    .SEGLED_PEN (SEGLED_PEN)
  );

  always #5 CLK = ~CLK;

  localparam int SrcAn   = 0;
  localparam int SrcSeg  = 1;
  localparam int SrcPen  = 2;
  localparam int SrcClr  = 3;
  localparam int SrcScan = 4;

  typedef struct {
    string       name;
    int          src;
    logic [15:0] exp;
  } probe_t;

  probe_t      probe_q[$];
  logic [63:0] frame_exp_q[$];
  int          n_vec = 0;
  int          n_bad = 0;

  function automatic logic [4:0] seg_to_nib(input logic [7:0] s);
    case (s)
      8'hC0: return 5'h10; 8'hF9: return 5'h11; 8'hA4: return 5'h12; 8'hB0: return 5'h13;
      8'h99: return 5'h14; 8'h92: return 5'h15; 8'h82: return 5'h16; 8'hF8: return 5'h17;
      8'h80: return 5'h18; 8'h90: return 5'h19; 8'h88: return 5'h1A; 8'h83: return 5'h1B;
      8'hC6: return 5'h1C; 8'hA1: return 5'h1D; 8'h86: return 5'h1E; 8'h8E: return 5'h1F;
      default: return 5'h00;
    endcase
  endfunction

  // Reassemble the four scanned digits as seen on the pins.
  logic [15:0] scan_word = '0;
  logic [3:0]  scan_seen = '0;
  always @(negedge CLK) begin
    logic [4:0] n;
    int         d;
    n = seg_to_nib(SEGMENT);
    d = -1;
    case (AN)
      4'b1110: d = 0;
      4'b1101: d = 1;
      4'b1011: d = 2;
      4'b0111: d = 3;
      default: d = -1;
    endcase
    if (d >= 0 && n[4]) begin
      scan_word[4*d +: 4] = n[3:0];
      scan_seen[d]        = 1'b1;
    end
  end

  initial begin
    forever begin
      @(negedge CLK);
      #1;
      while (probe_q.size() > 0) begin
        probe_t      p;
        logic [15:0] act;
        p = probe_q.pop_front();
        case (p.src)
          SrcAn:   act = {12'b0, AN};
          SrcSeg:  act = {8'b0, SEGMENT};
          SrcPen:  act = {15'b0, SEGLED_PEN};
          SrcClr:  act = {15'b0, SEGLED_CLR};
          default: act = scan_word;
        endcase
        n_vec++;
        if (act !== p.exp) begin
          n_bad++;
          $display("FAIL %s: got %h expected %h", p.name, act, p.exp);
        end
      end
    end
  end

  logic [63:0] cap = '0;
  int          cap_n = 0;
  int          last_n = 0;
  always @(posedge SEGLED_CLK) begin
    cap   = {cap[62:0], SEGLED_DO};
    cap_n = cap_n + 1;
  end

  always @(negedge CLK) begin
    if (SEGLED_PEN) begin
      if (frame_exp_q.size() > 0) begin
        logic [63:0] e;
        e = frame_exp_q.pop_front();
        n_vec++;
        if (cap !== e) begin
          n_bad++;
          $display("FAIL serial_frame: got %h expected %h", cap, e);
        end
        n_vec++;
        if (cap_n - last_n != 64) begin
          n_bad++;
          $display("FAIL serial_clk_pulses: got %0d expected 64", cap_n - last_n);
        end
      end
      last_n = cap_n;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic push(input string name, input int src, input logic [15:0] exp);
    probe_t p;
    p.name = name;
    p.src  = src;
    p.exp  = exp;
    probe_q.push_back(p);
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  task automatic check_scan(input logic [2:0] mode, input logic [4:0] ridx,
                            input logic [15:0] exp, input string name);
    SW[15:13] = mode;
    SW[4:0]   = ridx;
    tick(2);
    scan_seen = '0;
    for (int i = 0; i < 200 && scan_seen != 4'hF; i++) tick(1);
    if (scan_seen != 4'hF) timeout(name);
    else push(name, SrcScan, exp);
    tick(1);
  endtask

  task automatic do_step();
    SW[5] = 1'b1;
    tick(4);
    SW[5] = 1'b0;
    tick(4);
  endtask

  task automatic wait_pen(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      tick(1);
      ok = SEGLED_PEN;
    end
    if (!ok) timeout(name);
  endtask

  initial begin
    bit ok;
    Reset = 1'b0;
    SW    = '0;
    tick(3);
    push("reset_an", SrcAn, 16'h000F);
    push("reset_seg", SrcSeg, 16'h00FF);
    push("reset_pen", SrcPen, 16'h0000);
    push("reset_clr", SrcClr, 16'h0001);
    tick(1);
    Reset = 1'b1;
    check_scan(3'b000, 5'd0, 16'h0000, "pc_after_reset");

    do_step();
    check_scan(3'b111, 5'd29, 16'h00FC, "reg29_after_step1");

    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick(1);
      ok = (AN == 4'b1110);
    end
    if (!ok) timeout("an_sync");
    else begin
      tick(16);
      push("an_digit1", SrcAn, 16'h000D);
      tick(16);
      push("an_digit2", SrcAn, 16'h000B);
      tick(16);
      push("an_digit3", SrcAn, 16'h0007);
      tick(1);
    end

    // A frame already in flight may hold stale data; expect the next whole one.
    wait_pen("pen_sync", ok);
    if (ok) begin
      tick(1);
      frame_exp_q.push_back(64'hC0C0_C0C0_C0C0_8EC6);
      wait_pen("pen_frame", ok);
      if (ok) begin
        tick(1);
        push("pen_one_cycle", SrcPen, 16'h0000);
        tick(1);
      end
    end

    for (int i = 0; i < 7; i++) do_step();
    check_scan(3'b111, 5'd3, 16'h000A, "reg3_add");
    check_scan(3'b111, 5'd4, 16'h0006, "reg4_sub");
    check_scan(3'b111, 5'd5, 16'h0000, "reg5_and");
    check_scan(3'b111, 5'd6, 16'h000A, "reg6_or");
    check_scan(3'b111, 5'd7, 16'h0001, "reg7_slt");
    check_scan(3'b000, 5'd0, 16'h0020, "pc_after_8");

    do_step();
    check_scan(3'b000, 5'd0, 16'h0028, "pc_after_beq");
    check_scan(3'b111, 5'd8, 16'h0000, "reg8_skipped");
    check_scan(3'b001, 5'd0, 16'h0000, "next_pc_jump");

    do_step();
    check_scan(3'b000, 5'd0, 16'h0000, "pc_after_j");

    SW[5] = 1'b1;
    tick(100);
    check_scan(3'b000, 5'd0, 16'h0004, "pc_after_hold");
    check_scan(3'b001, 5'd0, 16'h0008, "next_pc_at_4");
    check_scan(3'b010, 5'd0, 16'h0001, "rs_rt_idx_at_4");
    check_scan(3'b011, 5'd0, 16'h0000, "rs_data_at_4");
    check_scan(3'b100, 5'd0, 16'h0008, "rt_data_at_4");
    check_scan(3'b101, 5'd0, 16'h0008, "alu_at_4");
    check_scan(3'b110, 5'd0, 16'h0008, "instr_lo_at_4");
    SW[5] = 1'b0;

    for (int i = 0; i < 20 && probe_q.size() > 0; i++) tick(1);
    if (probe_q.size() > 0) timeout("probe_drain");
    if (frame_exp_q.size() > 0) timeout("frame_drain");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
